// File: rtl/wrr_vc_mux.sv
// wrr_vc_mux: weighted round-robin merge of NUM_VC valid/ready channels into
// one registered output stream. Each VC gets up to weight[vc] consecutive
// words per turn, then the grant rotates to the next eligible VC.

// Per-VC lane: eligibility and the accept strobe for one channel.
module wrr_vc_lane #(
  parameter int WEIGHT_W = 4
) (
  input  logic                valid,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic                sel,
  output logic                elig,
  output logic                ready
);
  // A zero weight removes the VC from arbitration entirely.
  assign elig  = valid && (weight != '0);
  assign ready = sel && elig;
endmodule

module wrr_vc_mux #(
  parameter int NUM_VC   = 4,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 4,
  parameter int ID_W     = $clog2(NUM_VC)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_VC-1:0]            in_valid,
  input  logic [NUM_VC*DATA_W-1:0]     in_data,
  output logic [NUM_VC-1:0]            in_ready,
  input  logic [NUM_VC*WEIGHT_W-1:0]   weight,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [ID_W-1:0]              out_vc_id,
  input  logic                         out_ready
);

  localparam logic [ID_W:0] NVC = (ID_W+1)'(NUM_VC);

  logic [NUM_VC-1:0][DATA_W-1:0]   data_arr;
  logic [NUM_VC-1:0][WEIGHT_W-1:0] wt_arr;
  logic [NUM_VC-1:0]               elig;
  logic [NUM_VC-1:0]               gnt_oh;

  logic                load;
  logic                stay;
  logic                gnt_vld;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W:0]       cand;

  logic [ID_W-1:0]     cur_q, cur_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]     out_vc_q, out_vc_d;

  // Packed-array views: VC i lands at element i, matching the flat layout.
  assign data_arr = in_data;
  assign wt_arr   = weight;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_lane
    assign gnt_oh[i] = gnt_vld && (gnt_id == ID_W'(i));
    wrr_vc_lane #(.WEIGHT_W(WEIGHT_W)) u_lane (
      .valid  (in_valid[i]),
      .weight (wt_arr[i]),
      .sel    (gnt_oh[i]),
      .elig   (elig[i]),
      .ready  (in_ready[i])
    );
  end

  // Arbitration: keep cur while it has credit, else first eligible VC after cur.
  always_comb begin
    load    = !out_valid_q || out_ready;
    stay    = elig[cur_q] && (cnt_q < wt_arr[cur_q]);
    gnt_vld = 1'b0;
    gnt_id  = cur_q;
    cand    = '0;
    if (stay) begin
      gnt_vld = 1'b1;
    end else begin
      // Offset NUM_VC wraps back to cur, so a lone requester restarts its turn.
      for (int k = 1; k <= NUM_VC; k++) begin
        cand = {1'b0, cur_q} + (ID_W+1)'(k);
        if (cand >= NVC) cand = cand - NVC;
        if (!gnt_vld && elig[cand[ID_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_id  = cand[ID_W-1:0];
        end
      end
    end
    // No accept while the output register is stalled or reset is held.
    if (!load || reset) gnt_vld = 1'b0;
  end

  // Turn state and output register next-state.
  always_comb begin
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_vc_d    = out_vc_q;
    if (gnt_vld) begin
      if (stay) begin
        cnt_d = cnt_q + WEIGHT_W'(1);
      end else begin
        cur_d = gnt_id;
        cnt_d = WEIGHT_W'(1);
      end
      out_data_d = data_arr[gnt_id];
      out_vc_d   = gnt_id;
    end
    if (load) out_valid_d = gnt_vld;
  end

  // State registers; synchronous reset drops any registered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_vc_q    <= '0;
    end else begin
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_vc_q    <= out_vc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_vc_id = out_vc_q;

endmodule

// File: tb/tb_wrr_vc_mux.sv
// Directed bench for wrr_vc_mux: expected (vc, data) words are queued as each
// step is driven and popped as the output handshakes.
module tb_wrr_vc_mux;
  localparam int NUM_VC = 4;
  localparam int DATA_W = 8;
  localparam int WEIGHT_W = 4;
  localparam int ID_W = 2;

  typedef struct packed {
    logic [ID_W-1:0]   vc;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NUM_VC-1:0]          in_valid;
  logic [NUM_VC*DATA_W-1:0]   in_data;
  logic [NUM_VC-1:0]          in_ready;
  logic [NUM_VC*WEIGHT_W-1:0] weight;
  logic                       out_valid;
  logic [DATA_W-1:0]          out_data;
  logic [ID_W-1:0]            out_vc_id;
  logic                       out_ready;

  exp_t q[$];
  int   seq[NUM_VC];
  int   exp_seq[NUM_VC];
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_vc1_off = 0;
  bit   need_valid = 0;

  wrr_vc_mux #(.NUM_VC(NUM_VC), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .weight(weight), .out_valid(out_valid),
    .out_data(out_data), .out_vc_id(out_vc_id), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Each source emits {vc, word index} so lost or repeated words show up.
  always_comb begin
    in_data = '0;
    for (int v = 0; v < NUM_VC; v++)
      in_data[v*DATA_W +: DATA_W] = 8'((v << 4) | (seq[v] & 15));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int vc);
    exp_t e;
    e.vc   = ID_W'(vc);
    e.data = 8'((vc << 4) | (exp_seq[vc] & 15));
    exp_seq[vc]++;
    q.push_back(e);
  endtask

  task automatic push_list(input int n, input logic [31:0] ids [16]);
    for (int i = 0; i < n; i++) push(int'(ids[i]));
  endtask

  // One clock: observe mid-cycle, then advance sources that were accepted.
  task automatic cycle();
    logic [NUM_VC-1:0] hs;
    exp_t e;
    @(negedge clk);
    hs = in_valid & in_ready;
    if (reset) chk("rst_in_ready", 32'(in_ready), 32'd0);
    if (chk_vc1_off) chk("vc1_never_granted", 32'(in_ready[1]), 32'd0);
    if (need_valid) chk("no_bubble", 32'(out_valid), 32'd1);
    if (out_valid && out_ready) begin
      vectors++;
      assert (q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_word observed vc=%0d data=%0h expected none", out_vc_id, out_data);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_vc_id", 32'(out_vc_id), 32'(e.vc));
        chk("out_data", 32'(out_data), 32'(e.data));
      end
    end
    @(posedge clk);
    #1;
    for (int v = 0; v < NUM_VC; v++) if (hs[v]) seq[v]++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain_and_reset();
    in_valid = '0;
    run(3);
    chk("queue_drained", 32'(q.size()), 32'd0);
    q.delete();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] ids [16];
    for (int v = 0; v < NUM_VC; v++) begin seq[v] = 0; exp_seq[v] = 0; end
    reset = 1'b1; in_valid = '0; out_ready = 1'b1;
    weight = {4'd4, 4'd3, 4'd2, 4'd1};
    run(2);
    in_valid = '1;
    cycle();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_vc_id", 32'(out_vc_id), 32'd0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
    reset = 1'b0;

    // Weighted rotation, weights {1,2,3,4}
    ids = '{0,1,1,2,2,2,3,3,3,3,0,1,1,0,0,0};
    push_list(13, ids);
    in_valid = '1;
    need_valid = 1'b0;
    cycle();
    need_valid = 1'b1;
    run(12);
    in_valid = '0;
    cycle();
    need_valid = 1'b0;
    drain_and_reset();

    // Backpressure: stall 5 cycles with a word held
    ids = '{0,1,1,2,2,2,0,0,0,0,0,0,0,0,0,0};
    push_list(6, ids);
    in_valid = '1;
    run(3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_vc_id", 32'(out_vc_id), 32'(q[0].vc));
      chk("bp_out_data", 32'(out_data), 32'(q[0].data));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    run(3);
    drain_and_reset();

    // Disabled channel, weights {2,0,1,1}
    weight = {4'd1, 4'd1, 4'd0, 4'd2};
    ids = '{0,0,2,3,0,0,2,3,0,0,0,0,0,0,0,0};
    push_list(8, ids);
    in_valid = '1;
    chk_vc1_off = 1'b1;
    run(8);
    chk_vc1_off = 1'b0;
    drain_and_reset();

    // Early burst end: VC1 drops after one word, VC2 follows with no gap
    weight = {4'd3, 4'd3, 4'd3, 4'd3};
    ids = '{0,0,0,1,2,2,2,0,0,0,0,0,0,0,0,0};
    push_list(7, ids);
    in_valid = '1;
    cycle();
    need_valid = 1'b1;
    run(3);
    in_valid = 4'b1101;
    run(3);
    in_valid = '0;
    cycle();
    need_valid = 1'b0;
    drain_and_reset();

    // Sole requester VC2 (weight 2); then VC0 joins at cnt=2
    weight = {4'd1, 4'd2, 4'd1, 4'd1};
    ids = '{2,2,2,2,0,0,0,0,0,0,0,0,0,0,0,0};
    push_list(5, ids);
    in_valid = 4'b0100;
    cycle(); chk("sole_cnt1", 32'(dut.cnt_q), 32'd1);
    cycle(); chk("sole_cnt2", 32'(dut.cnt_q), 32'd2);
    cycle(); chk("sole_cnt3", 32'(dut.cnt_q), 32'd1);
    cycle(); chk("sole_cnt4", 32'(dut.cnt_q), 32'd2);
    in_valid = 4'b0101;
    cycle();
    chk("join_cur", 32'(dut.cur_q), 32'd0);
    chk("join_cnt", 32'(dut.cnt_q), 32'd1);
    drain_and_reset();

    // Reset during VC3's second of four words
    weight = {4'd4, 4'd3, 4'd2, 4'd1};
    ids = '{0,1,1,2,2,2,3,0,0,0,0,0,0,0,0,0};
    push_list(7, ids);
    in_valid = '1;
    run(7);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_vc_id", 32'(out_vc_id), 32'd0);
    chk("mid_rst_cur", 32'(dut.cur_q), 32'd0);
    chk("mid_rst_cnt", 32'(dut.cnt_q), 32'd0);
    push(0);
    push(1);
    run(2);
    chk("post_rst_vc0_first", 32'(dut.cur_q), 32'd1);
    drain_and_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wrr_vc_mux.md
# wrr_vc_mux

Parametrised weighted round-robin virtual-channel multiplexer for the WRR datapath. It merges `NUM_VC` valid/ready input channels of `DATA_W` bits into one registered output stream. Each channel may send up to its programmable weight of consecutive words per turn before the grant rotates. It replaces the fixed 4:1, 1-bit VC selector with a flow-controlled, weight-aware arbiter and output stage.

## Interface
- `NUM_VC`, default 4: number of virtual channels, ≥2.
- `DATA_W`, default 8: data word width.
- `WEIGHT_W`, default 4: width of each per-VC weight and of the burst counter.
- `ID_W`, default `$clog2(NUM_VC)`: width of the VC identifier.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: reset, synchronous, active-high.
- `in_valid`  in  NUM_VC: per-VC word available.
- `in_data`  in  NUM_VC*DATA_W: VC i occupies bits [i*DATA_W +: DATA_W].
- `in_ready`  out  NUM_VC: per-VC accept; at most one bit high.
- `weight`  in  NUM_VC*WEIGHT_W: VC i weight at [i*WEIGHT_W +: WEIGHT_W]; 0 disables VC i.
- `out_valid`  out  1: output word valid.
- `out_data`  out  DATA_W: output word.
- `out_vc_id`  out  ID_W: source VC of `out_data`.
- `out_ready`  in  1: downstream accept.

## Operation
- Internal state: `cur` (ID_W, current VC), `cnt` (WEIGHT_W, words granted to `cur` this turn), and the output register.
- The output register loads when `load = !out_valid || out_ready`.
- A VC is eligible when its `in_valid` is 1 and its `weight` is non-zero.
- Arbitration is evaluated only when `load` = 1:
  - Stay: if `cur` is eligible and `cnt < weight[cur]`, grant `cur` and set `cnt <= cnt + 1`.
  - Rotate: otherwise, search offsets 1..NUM_VC from `cur` (wrapping modulo NUM_VC). Grant the first eligible VC `g`, then set `cur <= g` and `cnt <= 1`. Offset NUM_VC is `cur` itself, so a sole eligible VC starts a fresh turn.
  - No eligible VC: no grant; `cur` and `cnt` are unchanged.
- On a grant to `g`:
  - `in_ready[g] = 1` in that cycle, combinationally.
  - Next edge: `out_data <= in_data[g]`, `out_vc_id <= g`, `out_valid <= 1`.
- When `load` = 1 with no grant: `out_valid <= 0`; `out_data` and `out_vc_id` hold.
- When `load` = 0: `in_ready` is all zeros and the output register holds (backpressure).
- A burst ends early if `cur` drops `in_valid`; the grant rotates immediately, with no idle cycle.
- Weight may change at any time and takes effect on the next evaluation. If `cnt >= weight[cur]` after a change, `cur` is exhausted and the grant rotates.
- `cnt` never exceeds `weight[cur]`, so it never wraps.
- `in_ready` depends combinationally on `in_valid`, `weight` and `out_ready`. No `in_valid` depends on `in_ready`.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `out_vc_id` = 0, `cur` = 0, `cnt` = 0, `in_ready` = 0 during reset.
- After reset the first arbitration uses `cur` = 0, `cnt` = 0, so VC0 wins first if it is eligible.
- Latency: one cycle from the accept handshake (`in_valid[g] && in_ready[g]`) to `out_valid` with that word.
- Throughput: one word per cycle while `out_ready` = 1 and any VC is eligible.
- Reset asserted mid-burst has priority over everything:
  - State returns to reset values on that edge.
  - The registered word is dropped.
  - No `in_ready` is asserted while `reset` = 1.

## Test plan
- Weighted rotation: NUM_VC=4, weights {1,2,3,4}, all `in_valid`=1, `out_ready`=1. Required `out_vc_id` sequence is 0,1,1,2,2,2,3,3,3,3,0,1,1, with one word per cycle and each word matching its source VC's data.
- Backpressure: hold `out_ready`=0 for 5 cycles while `out_valid`=1. `out_data` and `out_vc_id` stay stable and `in_ready` is 0000. After release, the sequence resumes with no word lost or duplicated.
- Disabled channel: weights {2,0,1,1}, all valid. Required sequence is 0,0,2,3,0,0,2,3, and VC1 is never granted.
- Early burst end: weights all 3. VC1 drops `in_valid` after its first grant. The next grant is VC2, with no idle cycle.
- Sole requester: only VC2 valid, weight 2. VC2 is granted every cycle, with `cnt` going 1,2,1,2. VC0 then asserts while VC2 is at `cnt`=2; the next grant goes to VC3 if eligible, otherwise VC0.
- Reset mid-burst: assert `reset` for 1 cycle during VC3's second of 4 words. The next cycle shows `out_valid`=0, and the first post-reset grant is VC0 when all VCs are valid.
